// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory initiator with byte lanes and load extension.
// Define MISALIGNED_SPLIT_EN to split misaligned accesses into two word transactions.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_ctrl,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

`ifdef MISALIGNED_SPLIT_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    WAIT0  = 3'd2,
    ISSUE1 = 3'd3,
    WAIT1  = 3'd4,
    RESP   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    WAIT0  = 3'd2,
    RESP   = 3'd5
  } state_t;
`endif

  state_t     state;
  logic [2:0] ctrl_q;
  logic [1:0] off_q;
`ifdef MISALIGNED_SPLIT_EN
  logic [ADDR_W-3:0] word_q;
  logic [31:0]       wdata_q;
  logic [31:0]       r0_q;
  logic              mis_q;
`endif

  function automatic logic [3:0] size_mask(input logic [2:0] c);
    logic [3:0] m;
    unique case (1'b1)
      c == 3'b010:                m = 4'hF;
      c == 3'b001 || c == 3'b011: m = 4'h3;
      default:                    m = 4'h1;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] lane_be(
    input logic [2:0] c,
    input logic [1:0] off,
    input logic       hi
  );
    logic [7:0] m;
    m = {4'b0, size_mask(c)} << off;
    return hi ? m[7:4] : m[3:0];
  endfunction

  function automatic logic [31:0] lane_data(
    input logic [31:0] w,
    input logic [1:0]  off,
    input logic        hi
  );
    logic [63:0] d;
    d = {32'b0, w} << {off, 3'b000};
    return hi ? d[63:32] : d[31:0];
  endfunction

  function automatic logic [31:0] load_ext(
    input logic [2:0]  c,
    input logic [1:0]  off,
    input logic [31:0] hi,
    input logic [31:0] lo
  );
    logic [31:0] v;
    logic [31:0] r;
    v = 32'({hi, lo} >> {off, 3'b000});
    unique case (1'b1)
      c == 3'b000: r = {{24{v[7]}}, v[7:0]};
      c == 3'b001: r = {{16{v[15]}}, v[15:0]};
      c == 3'b011: r = {16'b0, v[15:0]};
      c == 3'b100: r = {24'b0, v[7:0]};
      default:     r = v;
    endcase
    return r;
  endfunction

  logic req_mis;
  logic req_bad;

  assign req_mis = |lane_be(req_ctrl, req_addr[1:0], 1'b1);

  // unsigned-only sizes have no store form
`ifdef MISALIGNED_SPLIT_EN
  assign req_bad = req_ctrl > 3'b100 ||
                   (req_we && (req_ctrl == 3'b011 || req_ctrl == 3'b100));
`else
  assign req_bad = req_ctrl > 3'b100 || req_mis ||
                   (req_we && (req_ctrl == 3'b011 || req_ctrl == 3'b100));
`endif

  assign req_ready = rst_n && state == IDLE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ctrl_q    <= '0;
      off_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
`ifdef MISALIGNED_SPLIT_EN
      word_q    <= '0;
      wdata_q   <= '0;
      r0_q      <= '0;
      mis_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          ctrl_q <= req_ctrl;
          off_q  <= req_addr[1:0];
`ifdef MISALIGNED_SPLIT_EN
          word_q  <= req_addr[ADDR_W-1:2];
          wdata_q <= req_wdata;
          mis_q   <= req_mis;
`endif
          if (req_bad) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            state     <= ISSUE0;
            mem_valid <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_be    <= lane_be(req_ctrl, req_addr[1:0], 1'b0);
            mem_wdata <= lane_data(req_wdata, req_addr[1:0], 1'b0);
          end
        end
        ISSUE0: if (mem_ready) begin
          mem_valid <= 1'b0;
          if (!mem_we) begin
            state <= WAIT0;
`ifdef MISALIGNED_SPLIT_EN
          end else if (mis_q) begin
            state     <= ISSUE1;
            mem_valid <= 1'b1;
            mem_addr  <= {word_q + (ADDR_W-2)'(1), 2'b00};
            mem_be    <= lane_be(ctrl_q, off_q, 1'b1);
            mem_wdata <= lane_data(wdata_q, off_q, 1'b1);
`endif
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        WAIT0: if (mem_rvalid) begin
`ifdef MISALIGNED_SPLIT_EN
          if (mis_q) begin
            r0_q      <= mem_rdata;
            state     <= ISSUE1;
            mem_valid <= 1'b1;
            mem_addr  <= {word_q + (ADDR_W-2)'(1), 2'b00};
            mem_be    <= lane_be(ctrl_q, off_q, 1'b1);
            mem_wdata <= lane_data(wdata_q, off_q, 1'b1);
          end else
`endif
          begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_ext(ctrl_q, off_q, '0, mem_rdata);
          end
        end
`ifdef MISALIGNED_SPLIT_EN
        ISSUE1: if (mem_ready) begin
          mem_valid <= 1'b0;
          if (!mem_we) begin
            state <= WAIT1;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        WAIT1: if (mem_rvalid) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= load_ext(ctrl_q, off_q, mem_rdata, r0_q);
        end
`endif
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface for the RV32I core. Accepts one load/store request at a time from the execute stage, converts it into word-aligned memory transactions with byte enables and shifted write data, then aligns and sign/zero-extends load data into a single registered response. Sits between the core datapath and the data memory (or bus bridge). Optionally splits misaligned accesses into two word transactions.

## Interface
- ADDR_W, 32, byte-address width; memory addresses wrap modulo 2^ADDR_W.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_ctrl  in  3  size/sign: 000 B, 001 H, 010 W, 011 HU (load only), 100 BU (load only); 101–111 illegal.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected (illegal ctrl, or misaligned when splitting is disabled).
- mem_valid  out  1  memory transaction request.
- mem_ready  in  1  memory accepts transaction when mem_valid && mem_ready.
- mem_we  out  1  transaction is a write.
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- mem_be  out  4  byte enables; bit i = byte lane i.
- mem_wdata  out  32  lane-positioned write data.
- mem_rvalid  in  1  read data valid; exactly one per accepted read, ≥1 cycle after acceptance.
- mem_rdata  in  32  read word.

## Operation
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
- IDLE: req_ready=1. On req_valid, latch all req_* fields; if illegal → RESP with err; else → ISSUE0.
- Offset off = addr[1:0]; size n = 1/2/4 bytes. Misaligned iff off+n > 4 (H at off 3; W at off 1–3).
- Byte mask m = ((1<<n)-1) << off (8 bits); shifted data d = {32'b0, wdata} << 8*off (64 bits).
- ISSUE0: mem_addr = addr & ~3, mem_be = m[3:0], mem_wdata = d[31:0]. Hold all mem_* stable until mem_ready. On accept: write → (misaligned ? ISSUE1 : RESP); read → WAIT0.
- WAIT0: on mem_rvalid capture word r0; → (misaligned ? ISSUE1 : RESP).
- ISSUE1/WAIT1: same with mem_addr = (addr & ~3) + 4 (wrap), mem_be = m[7:4], mem_wdata = d[63:32]; read word r1.
- Load result: v = {r1, r0} >> 8*off (r1 = 0 if not split); B/H sign-extend bit 7/15, BU/HU zero-extend, W pass-through.
- RESP: rsp_valid=1 for one cycle with rsp_rdata/rsp_err; → IDLE.
- Illegal: HU/BU with req_we=1 also treated as illegal. Errors issue no memory transaction.
- mem_rvalid outside WAIT0/WAIT1 is ignored.

## Timing
- Reset (rst_n low at edge): state IDLE; rsp_valid, rsp_err, mem_valid, mem_we = 0; mem_be = 0; mem_addr, mem_wdata, rsp_rdata = 0; req_ready = 0 while rst_n low.
- Reset mid-transaction: abandon immediately; mem_valid low next cycle; late mem_rvalid ignored.
- Request accepted at edge T (req_valid && req_ready); mem_valid high from T+1.
- Aligned store, mem_ready=1: accepted T+1, rsp_valid at T+2.
- Aligned load, mem_ready=1, mem_rvalid one cycle after accept: rsp_valid at T+3.
- Error: rsp_valid at T+1, no mem_valid.
- Back-to-back: next request accepted in the cycle after RESP (req_ready high in IDLE only).

## Configuration
- MISALIGNED_SPLIT_EN defined: misaligned accesses split into two transactions as above.
- Not defined: misaligned accesses → RESP with rsp_err=1, rsp_rdata=0, no memory transaction; ISSUE1/WAIT1 not built.

## Test plan
- Reset: rst_n low 2 cycles mid-load in WAIT0 → IDLE, mem_valid=0, no rsp_valid, following mem_rvalid ignored.
- SB addr 0x103, wdata 0x000000A5 → mem_addr 0x100, mem_be 4'b1000, mem_wdata 0xA5000000, rsp_valid 2 cycles after accept.
- LB addr 0x102, memory 0x0080_0000 → rsp_rdata 0xFFFFFF80; LBU same → 0x00000080.
- mem_ready low 3 cycles on LW 0x200 → mem_valid/addr/be held stable; rsp_rdata = mem word.
- With MISALIGNED_SPLIT_EN: SW addr 0xFFFFFFFE, wdata 0x11223344 → txn 0xFFFFFFFC be 1100 wdata 0x33440000, then 0x00000000 be 0011 wdata 0x00001122; without: rsp_err=1, no mem_valid.
- req_ctrl 3'b110 or SBU-store (ctrl 100, we=1) → rsp_valid at T+1 with rsp_err=1, rsp_rdata=0.
